kitchen_grid_state: RTL and testbench

- Authoritative owner of the 8x13 kitchen object grid; feeds the static sprite renderer's packed object_grid input.
- Applies player interaction requests (pick/place, chop, extinguish, spawn) to a shadow grid and advances pot cooking timers once per frame.
- Publishes the shadow grid to the display grid only between frames, so the renderer never sees a mid-frame change.

---
 rtl/kitchen_grid_state.sv | 188 ++++++++++++++++++
 tb/tb_kitchen_grid_state.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/kitchen_grid_state.sv
// Owns the 8x13 kitchen object grid. Player requests edit a shadow copy, frame ticks advance
// pot timers, and the shadow is published to the display grid only between frames.
//
// state  | meaning
// IDLE   | waiting for a frame tick (or pended tick) or an action request
// ACT    | evaluating the latched request against shadow grid and held object
// SCAN   | walking the 104 cells, advancing pot cook/burn counters
// COMMIT | copying shadow grid to object_grid_out
module kitchen_grid_state #(
    parameter int COOK_FRAMES = 180,
    parameter int BURN_FRAMES = 240
) (
    input  logic                   pixel_clk_in,
    input  logic                   rst_in,
    input  logic                   frame_tick_in,
    input  logic                   action_valid_in,
    output logic                   action_ready_out,
    input  logic [1:0]             action_type_in,
    input  logic [2:0]             action_x_in,
    input  logic [3:0]             action_y_in,
    input  logic [3:0]             spawn_obj_in,
    output logic [3:0]             held_out,
    output logic                   action_done_out,
    output logic                   action_ok_out,
    output logic                   scan_busy_out,
    output logic [7:0][12:0][3:0]  object_grid_out
);

    typedef enum logic [1:0] {IDLE, ACT, SCAN, COMMIT} state_t;

    localparam logic [7:0] COOK_LIM = 8'(COOK_FRAMES);
    localparam logic [7:0] BURN_LIM = 8'(BURN_FRAMES);
    localparam logic [6:0] LAST_CELL = 7'd103;

    localparam logic [1:0] T_INTERACT   = 2'd0;
    localparam logic [1:0] T_CHOP       = 2'd1;
    localparam logic [1:0] T_EXTINGUISH = 2'd2;
    localparam logic [1:0] T_SPAWN      = 2'd3;

    state_t      state;
    logic        pending;
    logic [6:0]  scan_idx;
    logic [3:0]  shadow [0:103];
    logic [7:0]  cnt    [0:103];

    logic [1:0]  req_type;
    logic [2:0]  req_x;
    logic [3:0]  req_y;
    logic [3:0]  req_obj;

    logic        req_in_range;
    logic [6:0]  req_idx;
    logic [3:0]  cur;
    logic        act_ok;
    logic [3:0]  act_cell;
    logic [3:0]  act_held;
    logic [3:0]  sc_cell;
    logic [7:0]  sc_inc;

    assign action_ready_out = (state == IDLE) && !pending;
    assign scan_busy_out    = (state == SCAN) || (state == COMMIT);

    // Out-of-range columns are steered to cell 0 so the lookup never leaves the array.
    assign req_in_range = (req_y <= 4'd12);
    assign req_idx      = req_in_range ? (7'(req_x) * 7'd13 + 7'(req_y)) : 7'd0;
    assign cur          = shadow[req_idx];
    assign sc_cell      = shadow[scan_idx];
    assign sc_inc       = cnt[scan_idx] + 8'd1;

    always_comb begin
        act_ok   = 1'b0;
        act_cell = cur;
        act_held = held_out;
        if (req_in_range) begin
            case (req_type)
                T_INTERACT: begin
                    if (held_out == 4'd0 && (cur == 4'd1 || cur == 4'd2 || cur == 4'd3 ||
                                             cur == 4'd4 || cur == 4'd10)) begin
                        act_ok = 1'b1; act_held = cur;  act_cell = 4'd0;
                    end else if (held_out == 4'd3 && cur == 4'd7) begin
                        act_ok = 1'b1; act_held = 4'd4; act_cell = 4'd5;
                    end else if (held_out == 4'd2 && cur == 4'd5) begin
                        act_ok = 1'b1; act_held = 4'd0; act_cell = 4'd6;
                    end else if (held_out != 4'd0 && cur == 4'd0) begin
                        act_ok = 1'b1; act_held = 4'd0; act_cell = held_out;
                    end
                end
                T_CHOP: begin
                    if (cur == 4'd1) begin
                        act_ok = 1'b1; act_cell = 4'd2;
                    end
                end
                T_EXTINGUISH: begin
                    if (held_out == 4'd10 && cur == 4'd9) begin
                        act_ok = 1'b1; act_cell = 4'd0;
                    end else if (held_out == 4'd10 && cur == 4'd8) begin
                        act_ok = 1'b1; act_cell = 4'd5;
                    end
                end
                T_SPAWN: begin
                    if (cur == 4'd0 && req_obj <= 4'd10) begin
                        act_ok = 1'b1; act_cell = req_obj;
                    end
                end
                default: act_ok = 1'b0;
            endcase
        end
    end

    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < 104; i++) begin
                shadow[i] <= 4'd0;
                cnt[i]    <= 8'd0;
            end
            object_grid_out <= '0;
            held_out        <= 4'd0;
            action_done_out <= 1'b0;
            action_ok_out   <= 1'b0;
            state           <= IDLE;
            pending         <= 1'b0;
            scan_idx        <= 7'd0;
            req_type        <= 2'd0;
            req_x           <= 3'd0;
            req_y           <= 4'd0;
            req_obj         <= 4'd0;
        end else begin
            action_done_out <= 1'b0;
            action_ok_out   <= 1'b0;
            case (state)
                IDLE: begin
                    if (frame_tick_in || pending) begin
                        pending  <= 1'b0;
                        scan_idx <= 7'd0;
                        state    <= SCAN;
                    end else if (action_valid_in) begin
                        req_type <= action_type_in;
                        req_x    <= action_x_in;
                        req_y    <= action_y_in;
                        req_obj  <= spawn_obj_in;
                        state    <= ACT;
                    end
                end
                ACT: begin
                    action_done_out <= 1'b1;
                    action_ok_out   <= act_ok;
                    if (act_ok) begin
                        shadow[req_idx] <= act_cell;
                        cnt[req_idx]    <= 8'd0;
                        held_out        <= act_held;
                    end
                    if (frame_tick_in) pending <= 1'b1;
                    state <= IDLE;
                end
                SCAN: begin
                    // Limits are 1..255, so the transition always fires before the counter can wrap.
                    if (sc_cell == 4'd6) begin
                        if (sc_inc == COOK_LIM) begin
                            shadow[scan_idx] <= 4'd7;
                            cnt[scan_idx]    <= 8'd0;
                        end else begin
                            cnt[scan_idx] <= sc_inc;
                        end
                    end else if (sc_cell == 4'd7) begin
                        if (sc_inc == BURN_LIM) begin
                            shadow[scan_idx] <= 4'd8;
                            cnt[scan_idx]    <= 8'd0;
                        end else begin
                            cnt[scan_idx] <= sc_inc;
                        end
                    end else begin
                        cnt[scan_idx] <= 8'd0;
                    end
                    if (scan_idx == LAST_CELL) state <= COMMIT;
                    else                       scan_idx <= scan_idx + 7'd1;
                end
                COMMIT: begin
                    for (int x = 0; x < 8; x++)
                        for (int y = 0; y < 13; y++)
                            object_grid_out[x][y] <= shadow[x*13 + y];
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_kitchen_grid_state.sv
// Directed bench for kitchen_grid_state with short cook/burn limits (3 and 2 frames).
module tb_kitchen_grid_state;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  tick = 1'b0;
    logic                  valid = 1'b0;
    logic                  ready;
    logic [1:0]            typ = 2'd0;
    logic [2:0]            ax = 3'd0;
    logic [3:0]            ay = 4'd0;
    logic [3:0]            obj = 4'd0;
    logic [3:0]            held;
    logic                  done;
    logic                  ok;
    logic                  busy;
    logic [7:0][12:0][3:0] grid;

    int tests = 0;
    int fails = 0;
    int n;

    localparam logic [1:0] INTERACT = 2'd0, CHOP = 2'd1, EXT = 2'd2, SPAWN = 2'd3;

    kitchen_grid_state #(.COOK_FRAMES(3), .BURN_FRAMES(2)) dut (
        .pixel_clk_in    (clk),
        .rst_in          (rst),
        .frame_tick_in   (tick),
        .action_valid_in (valid),
        .action_ready_out(ready),
        .action_type_in  (typ),
        .action_x_in     (ax),
        .action_y_in     (ay),
        .spawn_obj_in    (obj),
        .held_out        (held),
        .action_done_out (done),
        .action_ok_out   (ok),
        .scan_busy_out   (busy),
        .object_grid_out (grid)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic act(input logic [1:0] t, input logic [2:0] x, input logic [3:0] y,
                       input logic [3:0] o, input logic exp_ok, input string tag);
        typ = t; ax = x; ay = y; obj = o; valid = 1'b1;
        step();
        valid = 1'b0;
        chk({tag, "_nodone"}, 32'(done), 32'd0);
        step();
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_ok"}, 32'(ok), 32'(exp_ok));
    endtask

    // Pulses a tick and waits (bounded) for SCAN+COMMIT to finish: 105 busy cycles.
    task automatic frame(input string tag);
        int c;
        tick = 1'b1;
        step();
        tick = 1'b0;
        c = 0;
        while (busy && c < 300) begin
            c++;
            step();
        end
        chk({tag, "_len"}, 32'(c), 32'd105);
    endtask

    initial begin
        repeat (3) step();
        rst = 1'b0;
        chk("rst_held", 32'(held), 32'd0);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_grid", 32'(grid == '0), 32'd1);

        // Spawn is invisible until the next commit
        act(SPAWN, 3'd3, 4'd4, 4'd1, 1'b1, "spawn34");
        chk("g34_pre", 32'(grid[3][4]), 32'd0);
        frame("f0");
        chk("g34_post", 32'(grid[3][4]), 32'd1);

        // Chop, pick up, fill a pot
        act(SPAWN, 3'd0, 4'd0, 4'd1, 1'b1, "spawn00");
        act(CHOP, 3'd0, 4'd0, 4'd0, 1'b1, "chop00");
        act(CHOP, 3'd0, 4'd0, 4'd0, 1'b0, "chop00_again");
        act(INTERACT, 3'd0, 4'd0, 4'd0, 1'b1, "pick00");
        chk("held_chopped", 32'(held), 32'd2);
        act(SPAWN, 3'd0, 4'd1, 4'd5, 1'b1, "spawn_pot");
        act(INTERACT, 3'd0, 4'd1, 4'd0, 1'b1, "fill_pot");
        chk("held_after_fill", 32'(held), 32'd0);

        // Cook 3 frames then burn 2 frames
        frame("f1");
        chk("g00", 32'(grid[0][0]), 32'd0);
        chk("cook1", 32'(grid[0][1]), 32'd6);
        frame("f2");
        chk("cook2", 32'(grid[0][1]), 32'd6);
        frame("f3");
        chk("cook3", 32'(grid[0][1]), 32'd7);
        frame("f4");
        chk("burn1", 32'(grid[0][1]), 32'd7);
        frame("f5");
        chk("burn2", 32'(grid[0][1]), 32'd8);
        chk("onion_untouched", 32'(grid[3][4]), 32'd1);

        // Extinguish
        act(EXT, 3'd0, 4'd1, 4'd0, 1'b0, "ext_nohold");
        act(SPAWN, 3'd0, 4'd2, 4'd10, 1'b1, "spawn_ext");
        act(INTERACT, 3'd0, 4'd2, 4'd0, 1'b1, "pick_ext");
        chk("held_ext", 32'(held), 32'd10);
        act(EXT, 3'd0, 4'd1, 4'd0, 1'b1, "ext_pot");
        chk("held_ext_kept", 32'(held), 32'd10);
        act(INTERACT, 3'd0, 4'd3, 4'd0, 1'b1, "drop_ext");
        chk("held_dropped", 32'(held), 32'd0);

        // Refill, cook to 7, serve into a bowl
        act(SPAWN, 3'd0, 4'd4, 4'd2, 1'b1, "spawn_chopped");
        act(INTERACT, 3'd0, 4'd4, 4'd0, 1'b1, "pick_chopped");
        act(INTERACT, 3'd0, 4'd1, 4'd0, 1'b1, "refill_pot");
        frame("f6");
        chk("extinguished", 32'(grid[0][1]), 32'd6);
        frame("f7");
        frame("f8");
        chk("recook", 32'(grid[0][1]), 32'd7);
        act(SPAWN, 3'd0, 4'd5, 4'd3, 1'b1, "spawn_bowl");
        act(INTERACT, 3'd0, 4'd5, 4'd0, 1'b1, "pick_bowl");
        act(INTERACT, 3'd0, 4'd1, 4'd0, 1'b1, "serve");
        chk("held_full", 32'(held), 32'd4);
        act(INTERACT, 3'd0, 4'd1, 4'd0, 1'b0, "serve_again");
        chk("held_still_full", 32'(held), 32'd4);
        frame("f9");
        chk("pot_empty", 32'(grid[0][1]), 32'd5);
        chk("ext_cell", 32'(grid[0][3]), 32'd10);

        // Tick and valid together: tick wins, request waits through the scan
        typ = SPAWN; ax = 3'd7; ay = 4'd12; obj = 4'd9; valid = 1'b1; tick = 1'b1;
        step();
        tick = 1'b0;
        n = 0;
        while (!ready && n < 300) begin
            n++;
            step();
        end
        chk("tick_prio_len", 32'(n), 32'd105);
        step();
        valid = 1'b0;
        chk("late_nodone", 32'(done), 32'd0);
        step();
        chk("late_done", 32'(done), 32'd1);
        chk("late_ok", 32'(ok), 32'd1);
        act(SPAWN, 3'd2, 4'd13, 4'd1, 1'b0, "spawn_y13");

        // Tick during ACT is pended
        typ = SPAWN; ax = 3'd1; ay = 4'd1; obj = 4'd3; valid = 1'b1;
        step();
        valid = 1'b0;
        tick = 1'b1;
        step();
        tick = 1'b0;
        chk("pend_done", 32'(done), 32'd1);
        chk("pend_ready", 32'(ready), 32'd0);
        step();
        chk("pend_busy", 32'(busy), 32'd1);
        n = 0;
        while (busy && n < 300) begin
            n++;
            step();
        end
        chk("pend_len", 32'(n), 32'd105);
        chk("g1_1", 32'(grid[1][1]), 32'd3);
        chk("g7_12", 32'(grid[7][12]), 32'd9);

        // Reset mid-scan
        tick = 1'b1;
        step();
        tick = 1'b0;
        repeat (49) step();
        chk("mid_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mrst_grid", 32'(grid == '0), 32'd1);
        chk("mrst_held", 32'(held), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_ready", 32'(ready), 32'd1);
        frame("f_after_rst");
        chk("shadow_cleared", 32'(grid == '0), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
